// File: rtl/systolic_result_drain_pkg.sv
`default_nettype none
// systolic_result_drain_pkg: drain FSM state type and size-decode helpers shared by the drain block.
// Revision: 1.0
package systolic_result_drain_pkg;

    localparam int MSIZE_W = 3;
    localparam int NDIM_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CAPTURE    = 2'd1,
        ST_DRAIN      = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } drain_state_t;

    // Zero or out-of-range requests select the full array.
    function automatic logic [NDIM_W-1:0] decode_size(input logic [MSIZE_W-1:0] msize,
                                                      input int size);
        if (msize == '0 || int'(msize) > size) begin
            return NDIM_W'(size);
        end
        return {1'b0, msize};
    endfunction

    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drain_saturate.sv
`default_nettype none
// drain_saturate: narrows a signed result to OUT_BITS; saturates with DRAIN_SAT_EN, else truncates.
// Revision: 1.0
module drain_saturate #(
    parameter int IN_BITS  = 21,
    parameter int OUT_BITS = 16
) (
    input  logic [IN_BITS-1:0]  i_data,
    output logic [OUT_BITS-1:0] o_data
);

`ifdef DRAIN_SAT_EN
    logic fits;

    // Value fits when every bit from the output sign position upward equals the sign.
    assign fits = (&i_data[IN_BITS-1:OUT_BITS-1]) | ~(|i_data[IN_BITS-1:OUT_BITS-1]);

    always_comb begin
        o_data = i_data[OUT_BITS-1:0];
        if (!fits) begin
            o_data = i_data[IN_BITS-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                       : {1'b0, {(OUT_BITS-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign o_data    = i_data[OUT_BITS-1:0];
    assign unused_hi = ^i_data;
`endif

endmodule
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// systolic_result_drain: snapshots the N x N result block once all active PEs finish and streams it
// row-major over valid/ready. Optional macro DRAIN_SAT_EN selects output saturation. Revision: 1.0
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int REG_C_BITS = 21,
    parameter int OUT_BITS   = 16
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic [SIZE*SIZE*REG_C_BITS-1:0] i_c_full,
    input  logic [SIZE*SIZE-1:0]            i_finish,
    input  logic [MSIZE_W-1:0]              i_matrix_size,
    input  logic                            i_ready,
    output logic [OUT_BITS-1:0]             o_data,
    output logic                            o_valid,
    output logic [$clog2(SIZE)-1:0]         o_row,
    output logic [$clog2(SIZE)-1:0]         o_col,
    output logic                            o_last,
    output logic                            o_busy
);

    localparam int IDX_W  = idx_width(SIZE);
    localparam int NUM_PE = SIZE * SIZE;

    drain_state_t          state_q, state_d;
    logic [IDX_W-1:0]      row_q, row_d;
    logic [IDX_W-1:0]      col_q, col_d;
    logic [NDIM_W-1:0]     n_q, n_d;
    logic [NDIM_W-1:0]     n_now;
    logic [REG_C_BITS-1:0] snap_q [NUM_PE];
    logic [REG_C_BITS-1:0] elem;
    logic                  all_fin;
    logic                  any_fin;
    logic                  at_row_end;
    logic                  at_last;

    assign n_now = decode_size(i_matrix_size, SIZE);

    // Start uses the requested size; the clear check uses the size that was captured.
    always_comb begin
        all_fin = 1'b1;
        any_fin = 1'b0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (r < int'(n_now) && c < int'(n_now) && !i_finish[r*SIZE+c]) begin
                    all_fin = 1'b0;
                end
                if (r < int'(n_q) && c < int'(n_q) && i_finish[r*SIZE+c]) begin
                    any_fin = 1'b1;
                end
            end
        end
    end

    always_comb begin
        elem = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (i == int'(row_q) * SIZE + int'(col_q)) begin
                elem = snap_q[i];
            end
        end
    end

    assign at_row_end = (int'(col_q) == int'(n_q) - 1);
    assign at_last    = at_row_end && (int'(row_q) == int'(n_q) - 1);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        n_d     = n_q;
        case (state_q)
            ST_IDLE: begin
                if (all_fin) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                n_d     = n_now;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_ready) begin
                    if (at_last) begin
                        state_d = ST_WAIT_CLEAR;
                    end else if (at_row_end) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            ST_WAIT_CLEAR: begin
                if (!any_fin) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            n_q     <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            n_q     <= n_d;
            if (state_q == ST_CAPTURE) begin
                for (int i = 0; i < NUM_PE; i++) begin
                    snap_q[i] <= i_c_full[i*REG_C_BITS +: REG_C_BITS];
                end
            end
        end
    end

    drain_saturate #(
        .IN_BITS  (REG_C_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_sat (
        .i_data (elem),
        .o_data (o_data)
    );

    assign o_valid = (state_q == ST_DRAIN);
    assign o_last  = o_valid && at_last;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_row   = row_q;
    assign o_col   = col_q;

endmodule
`default_nettype wire

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter SIZE, default 4: array dimension (PEs per row/column).
REQ-002 SHALL have parameter REG_C_BITS, default 21: width of one accumulated result element.
REQ-003 SHALL have parameter OUT_BITS, default 16: width of one streamed output element, 2..REG_C_BITS.
REQ-004 SHALL have port i_clock  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port i_reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_c_full  in  SIZE*SIZE*REG_C_BITS: array results; element (r,c) at bits [(r*SIZE+c)*REG_C_BITS +: REG_C_BITS], signed two's complement.
REQ-007 SHALL have port i_finish  in  SIZE*SIZE: per-PE done flags, bit r*SIZE+c.
REQ-008 SHALL have port i_matrix_size  in  3: active dimension N; values 1..SIZE used as-is, 0 or >SIZE treated as SIZE.
REQ-009 SHALL have port o_data  out  OUT_BITS: current result element.
REQ-010 SHALL have port o_valid  out  1: o_data/o_row/o_col/o_last valid.
REQ-011 SHALL have port i_ready  in  1: consumer accepts when o_valid & i_ready.
REQ-012 SHALL have ports o_row, o_col  out  $clog2(SIZE) each: index of current element.
REQ-013 SHALL have port o_last  out  1: current element is (N-1,N-1).
REQ-014 SHALL have port o_busy  out  1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> CAPTURE -> DRAIN -> WAIT_CLEAR -> IDLE.
REQ-016 IDLE: SHALL move to CAPTURE on the cycle all i_finish bits with r<N, c<N are high; bits outside N×N ignored.
REQ-017 CAPTURE (1 cycle): SHALL snapshot all SIZE*SIZE elements of i_c_full and latch N; DRAIN entered next cycle with row=col=0.
REQ-018 DRAIN: SHALL hold o_valid high and o_data/o_row/o_col/o_last stable until accepted; element order row-major over N×N only.
REQ-019 On accept SHALL advance col; col wraps to 0 and row increments at col=N-1; accept with o_last SHALL go to WAIT_CLEAR with o_valid low next cycle.
REQ-020 Latency: first o_valid SHALL assert 2 cycles after the all-finish cycle; with i_ready held high one element per cycle, N*N cycles total.
REQ-021 WAIT_CLEAR: SHALL return to IDLE only once all active i_finish bits are low, preventing re-capture of the same result.
REQ-022 Snapshot SHALL be unaffected by i_c_full/i_finish/i_matrix_size changes after CAPTURE.
REQ-023 N=1: single element with o_last high, row=col=0.

Reset
REQ-024 Asserted i_reset SHALL immediately force IDLE, o_valid=0, o_last=0, o_busy=0, o_data=0, o_row=0, o_col=0, snapshot cleared.
REQ-025 Reset mid-DRAIN SHALL discard remaining elements; after release the block SHALL wait in IDLE for a fresh all-finish condition (a still-high i_finish re-captures).

Configuration
REQ-026 With macro DRAIN_SAT_EN defined, o_data SHALL be the element saturated to signed OUT_BITS range [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-027 Without DRAIN_SAT_EN, o_data SHALL be the low OUT_BITS bits of the element (truncation).

Structure
REQ-028 Shared package SHALL hold FSM state typedef (IDLE, CAPTURE, DRAIN, WAIT_CLEAR) and size-decode/index-width constants.
REQ-029 Sub-module drain_saturate SHALL implement REG_C_BITS->OUT_BITS narrowing for both macro settings.

Verification
REQ-030 SIZE=4, N=4, C(r,c)=r*4+c, i_finish all high, i_ready=1 -> o_data 0..15 on 16 consecutive cycles, first 2 cycles after finish, o_last only with 15.
REQ-031 N=2, all 16 finish bits high, C as above -> outputs 0,1,4,5 with (row,col) (0,0),(0,1),(1,0),(1,1); o_last on 5.
REQ-032 i_ready toggled 1,0,0,1 during DRAIN -> element held stable while low, no skip or duplicate.
REQ-033 i_finish held high after drain completes -> no second stream; drop finish 1 cycle then raise -> exactly one new stream.
REQ-034 C(0,0)=70000, OUT_BITS=16 -> DRAIN_SAT_EN: 32767; without: 70000 mod 65536 = 4464; C(0,1)=-40000 -> -32768 / low 16 bits.
REQ-035 i_reset low after 5th accepted element -> o_valid=0 at once; after release with finish high, stream restarts at (0,0).
